rnf_excl_seq_tracker: RTL and testbench
=======================================

# rnf_excl_seq_tracker

Requester-side exclusive-access sequencer that sits between a core's exclusive load/store port and the RN TXREQ link. It tracks one reservation per logical processor (LPID) and issues Excl-tagged ReadNoSnp/WriteNoSnpFull flits toward the HN-F global monitor. It interprets the returned RespErr (EXOKAY/OK) and reports exclusive pass/fail back to the core. It also drops reservations on snoop-invalidate hits.

## Interface
- NUM_LP, 4: tracked LPIDs; must be ≤ 2^`CHIE_REQ_FLIT_LPID_WIDTH.
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- core_req_valid / core_req_ready  in/out  1  core request handshake.
- core_req_lpid  in  `CHIE_REQ_FLIT_LPID_WIDTH  requesting LP.
- core_req_store  in  1  0 = exclusive load, 1 = exclusive store.
- core_req_addr  in  `CHIE_REQ_FLIT_ADDR_WIDTH  byte address.
- txreq_valid / txreq_ready  out/in  1  flit handshake to link.
- txreq_opcode  out  `CHIE_REQ_FLIT_OPCODE_WIDTH  `CHIE_READNOSNP or `CHIE_WRITENOSNPFULL.
- txreq_excl  out  1  constant 1 while txreq_valid.
- txreq_lpid, txreq_addr  out  LPID/ADDR widths  copied from the accepted request.
- txreq_txnid  out  `CHIE_REQ_FLIT_TXNID_WIDTH  LPID zero-extended.
- rsp_valid  in  1  completion (CompData or Comp) for an outstanding exclusive.
- rsp_lpid  in  LPID width  LP of completion.
- rsp_resperr  in  2  2'b01 EXOKAY, 2'b00 OK; others treated as OK.
- snp_inv_valid  in  1  snoop invalidate observed.
- snp_inv_addr  in  ADDR width  snooped address.
- excl_result_valid  out  1  one-cycle pulse, no backpressure.
- excl_result_lpid  out  LPID width.
- excl_result_pass  out  1  1 = exclusive succeeded.

## Operation
- Per-LP FSM states: IDLE, LD_PEND, RSVD (holds line address), ST_PEND.
- Exclusive load accepted in IDLE or RSVD:
  - Enqueue ReadNoSnp and move to LD_PEND.
  - Any old reservation is discarded.
- Exclusive store accepted in RSVD, with cache-line address (bits [ADDR-1:`CACHE_BLOCK_OFFSET]) equal to the reservation: enqueue WriteNoSnpFull and move to ST_PEND.
- Exclusive store accepted in IDLE, or in RSVD with a line mismatch:
  - Local fail: no flit is sent.
  - Result pulse with pass=0.
  - LP moves to IDLE.
- Response in LD_PEND:
  - EXOKAY: move to RSVD, result pass=1.
  - OK: move to IDLE, result pass=0.
- Response in ST_PEND: move to IDLE; pass = (resperr == EXOKAY).
- Response for an LP in IDLE/RSVD is ignored (no state change, no result).
- snp_inv_valid: every RSVD LP whose line matches moves to IDLE silently. Pending states are unaffected.
- core_req_ready is low when any of the following holds:
  - the target LP is LD_PEND/ST_PEND;
  - the output flit buffer is full and not draining this cycle;
  - rsp_valid is high (response owns the result port).
- Same cycle, same LP, snoop clear and store acceptance: snoop wins; the store is evaluated against the post-clear state, so it local-fails.

## Timing
- Reset values:
  - all LPs IDLE;
  - txreq_valid=0; excl_result_valid=0;
  - all data outputs 0.
- Accepted request → txreq_valid in the next cycle (single registered slot). It is held stable until txreq_ready.
- Back-to-back issue is allowed when txreq_ready=1 (full throughput).
- Local fail → excl_result_valid in the next cycle.
- rsp_valid → excl_result_valid in the next cycle. The FSM update is visible in the same next cycle.
- At most one result per cycle; guaranteed by the rsp_valid gating of core_req_ready.
- Reset mid-transaction drops pending flits and reservations; any later responses are ignored (the LP is IDLE).

## Structure
- Shared package/defines (hnf/rnf defines header):
  - FSM state encodings (2 bits);
  - RESPERR EXOKAY/OK constants;
  - LPID-to-TXNID mapping macro.
- Natural sub-module: rnf_excl_lp_entry, one per LP in a generate loop. It holds the state and line address, and exports match/busy/reserved.
- Top level holds the flit buffer, request arbitration and the result register.

## Test plan
- Load LP1 @0x1040, rsp EXOKAY; store LP1 @0x1078 → WriteNoSnpFull flit, txnid=1; rsp EXOKAY → result lpid=1 pass=1, LP1 IDLE.
- Store LP2 with no prior load → no txreq_valid; one cycle later result lpid=2 pass=0.
- Load LP0 @0x2000, EXOKAY; snp_inv @0x2010; store LP0 @0x2000 → local fail, pass=0, no flit.
- Load LP3, rsp OK → result pass=0; subsequent store LP3 local-fails.
- txreq_ready held low 5 cycles after a load → flit stable; new requests stall (ready=0); accepted after the drain.
- rsp_valid LP1 concurrent with core request LP2 → core_req_ready=0 that cycle; LP2 accepted the next cycle; results never overlap.

Source files
------------

// File: rtl/rnf_excl_seq_tracker_pkg.sv
// Shared CHI-E field widths, opcodes, RespErr codes and per-LP exclusive FSM encoding
// for the requester-side exclusive sequencer.
package rnf_excl_seq_tracker_pkg;

  localparam int LPID_W             = 5;
  localparam int ADDR_W             = 48;
  localparam int TXNID_W            = 12;
  localparam int OPCODE_W           = 7;
  localparam int CACHE_BLOCK_OFFSET = 6;
  localparam int LINE_W             = ADDR_W - CACHE_BLOCK_OFFSET;

  localparam logic [OPCODE_W-1:0] OP_READNOSNP      = 7'h04;
  localparam logic [OPCODE_W-1:0] OP_WRITENOSNPFULL = 7'h1D;

  localparam logic [1:0] RESPERR_OK     = 2'b00;
  localparam logic [1:0] RESPERR_EXOKAY = 2'b01;

  typedef enum logic [1:0] {
    LP_IDLE    = 2'd0,
    LP_LD_PEND = 2'd1,
    LP_RSVD    = 2'd2,
    LP_ST_PEND = 2'd3
  } lp_state_t;

  // One outstanding exclusive per LP, so the LPID alone names the transaction.
  function automatic logic [TXNID_W-1:0] lpid_to_txnid(input logic [LPID_W-1:0] lpid);
    return {{(TXNID_W-LPID_W){1'b0}}, lpid};
  endfunction

endpackage

// File: rtl/rnf_excl_lp_entry.sv
// One LP's exclusive-access state and reserved line; exports busy/reserved and
// request/snoop line matches. State change is visible the cycle after its trigger.
module rnf_excl_lp_entry
  import rnf_excl_seq_tracker_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_go,
  input  logic              st_go,
  input  logic              st_fail,
  input  logic              rsp_hit,
  input  logic              rsp_exokay,
  input  logic              snp_inv_valid,
  input  logic [LINE_W-1:0] snp_line,
  input  logic [LINE_W-1:0] req_line,
  output logic              busy,
  output logic              reserved,
  output logic              req_match,
  output logic              snp_hit
);

  lp_state_t         state, state_nxt;
  logic [LINE_W-1:0] line, line_nxt;

  assign busy      = (state == LP_LD_PEND) || (state == LP_ST_PEND);
  assign reserved  = (state == LP_RSVD);
  assign req_match = reserved && (line == req_line);
  assign snp_hit   = snp_inv_valid && reserved && (line == snp_line);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LP_IDLE;
      line  <= '0;
    end else begin
      state <= state_nxt;
      line  <= line_nxt;
    end
  end

  // Responses and request acceptance never coincide: the top stalls requests under rsp_valid.
  always_comb begin
    state_nxt = state;
    line_nxt  = line;
    if (rsp_hit) begin
      case (state)
        LP_LD_PEND: state_nxt = rsp_exokay ? LP_RSVD : LP_IDLE;
        LP_ST_PEND: state_nxt = LP_IDLE;
        default:    state_nxt = state;
      endcase
    end else if (ld_go) begin
      state_nxt = LP_LD_PEND;
      line_nxt  = req_line;
    end else if (st_go) begin
      state_nxt = LP_ST_PEND;
    end else if (st_fail || snp_hit) begin
      state_nxt = LP_IDLE;
    end
  end

endmodule

// File: rtl/rnf_excl_seq_tracker.sv
// Exclusive load/store sequencer: one reservation per LPID, Excl flits to TXREQ, pass/fail to core.
// Flit and result are registered (1 cycle); core_req_ready drops for busy LP, full flit slot, or rsp_valid.
module rnf_excl_seq_tracker
  import rnf_excl_seq_tracker_pkg::*;
#(
  parameter int NUM_LP = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                core_req_valid,
  output logic                core_req_ready,
  input  logic [LPID_W-1:0]   core_req_lpid,
  input  logic                core_req_store,
  input  logic [ADDR_W-1:0]   core_req_addr,
  output logic                txreq_valid,
  input  logic                txreq_ready,
  output logic [OPCODE_W-1:0] txreq_opcode,
  output logic                txreq_excl,
  output logic [LPID_W-1:0]   txreq_lpid,
  output logic [ADDR_W-1:0]   txreq_addr,
  output logic [TXNID_W-1:0]  txreq_txnid,
  input  logic                rsp_valid,
  input  logic [LPID_W-1:0]   rsp_lpid,
  input  logic [1:0]          rsp_resperr,
  input  logic                snp_inv_valid,
  input  logic [ADDR_W-1:0]   snp_inv_addr,
  output logic                excl_result_valid,
  output logic [LPID_W-1:0]   excl_result_lpid,
  output logic                excl_result_pass
);

  localparam int IDX_W = (NUM_LP > 1) ? $clog2(NUM_LP) : 1;

  logic [NUM_LP-1:0] lp_busy, lp_rsvd, lp_match, lp_snp_hit, lp_sel, lp_rsp;
  logic [IDX_W-1:0]  req_idx, rsp_idx;
  logic              req_in_range, rsp_in_range;
  logic              acc, ld_go, st_go, st_fail, store_ok, rsp_acc, rsp_exokay;

  assign req_idx      = core_req_lpid[IDX_W-1:0];
  assign rsp_idx      = rsp_lpid[IDX_W-1:0];
  assign req_in_range = {1'b0, core_req_lpid} < (LPID_W+1)'(NUM_LP);
  assign rsp_in_range = {1'b0, rsp_lpid} < (LPID_W+1)'(NUM_LP);
  assign rsp_exokay   = (rsp_resperr == RESPERR_EXOKAY);

  // Untracked LPIDs are never accepted.
  assign core_req_ready = req_in_range && !lp_busy[req_idx] &&
                          (!txreq_valid || txreq_ready) && !rsp_valid;

  // A same-cycle snoop hit on the target line clears the reservation before the store sees it.
  assign store_ok = lp_match[req_idx] && !lp_snp_hit[req_idx];
  assign acc      = core_req_valid && core_req_ready;
  assign ld_go    = acc && !core_req_store;
  assign st_go    = acc && core_req_store && store_ok;
  assign st_fail  = acc && core_req_store && !store_ok;
  assign rsp_acc  = rsp_valid && rsp_in_range && lp_busy[rsp_idx];

  for (genvar i = 0; i < NUM_LP; i++) begin : g_lp
    assign lp_sel[i] = req_in_range && (req_idx == IDX_W'(i));
    assign lp_rsp[i] = rsp_valid && (rsp_lpid == LPID_W'(i));

    rnf_excl_lp_entry u_entry (
      .clk           (clk),
      .rst           (rst),
      .ld_go         (ld_go && lp_sel[i]),
      .st_go         (st_go && lp_sel[i]),
      .st_fail       (st_fail && lp_sel[i]),
      .rsp_hit       (lp_rsp[i]),
      .rsp_exokay    (rsp_exokay),
      .snp_inv_valid (snp_inv_valid),
      .snp_line      (snp_inv_addr[ADDR_W-1:CACHE_BLOCK_OFFSET]),
      .req_line      (core_req_addr[ADDR_W-1:CACHE_BLOCK_OFFSET]),
      .busy          (lp_busy[i]),
      .reserved      (lp_rsvd[i]),
      .req_match     (lp_match[i]),
      .snp_hit       (lp_snp_hit[i])
    );
  end

  assign txreq_excl = txreq_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txreq_valid  <= 1'b0;
      txreq_opcode <= '0;
      txreq_lpid   <= '0;
      txreq_addr   <= '0;
      txreq_txnid  <= '0;
    end else if (ld_go || st_go) begin
      txreq_valid  <= 1'b1;
      txreq_opcode <= ld_go ? OP_READNOSNP : OP_WRITENOSNPFULL;
      txreq_lpid   <= core_req_lpid;
      txreq_addr   <= core_req_addr;
      txreq_txnid  <= lpid_to_txnid(core_req_lpid);
    end else if (txreq_ready) begin
      txreq_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      excl_result_valid <= 1'b0;
      excl_result_lpid  <= '0;
      excl_result_pass  <= 1'b0;
    end else begin
      excl_result_valid <= rsp_acc || st_fail;
      if (rsp_acc) begin
        excl_result_lpid <= rsp_lpid;
        excl_result_pass <= rsp_exokay;
      end else if (st_fail) begin
        excl_result_lpid <= core_req_lpid;
        excl_result_pass <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rnf_excl_seq_tracker.sv
// Directed bench for rnf_excl_seq_tracker: exclusive load/store sequences, snoop clears,
// link backpressure, response/request collision and mid-transaction reset.
module tb_rnf_excl_seq_tracker;
  import rnf_excl_seq_tracker_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                core_req_valid, core_req_ready, core_req_store;
  logic [LPID_W-1:0]   core_req_lpid;
  logic [ADDR_W-1:0]   core_req_addr;
  logic                txreq_valid, txreq_ready, txreq_excl;
  logic [OPCODE_W-1:0] txreq_opcode;
  logic [LPID_W-1:0]   txreq_lpid;
  logic [ADDR_W-1:0]   txreq_addr;
  logic [TXNID_W-1:0]  txreq_txnid;
  logic                rsp_valid;
  logic [LPID_W-1:0]   rsp_lpid;
  logic [1:0]          rsp_resperr;
  logic                snp_inv_valid;
  logic [ADDR_W-1:0]   snp_inv_addr;
  logic                excl_result_valid, excl_result_pass;
  logic [LPID_W-1:0]   excl_result_lpid;

  int total = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  rnf_excl_seq_tracker #(.NUM_LP(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .core_req_valid    (core_req_valid),
    .core_req_ready    (core_req_ready),
    .core_req_lpid     (core_req_lpid),
    .core_req_store    (core_req_store),
    .core_req_addr     (core_req_addr),
    .txreq_valid       (txreq_valid),
    .txreq_ready       (txreq_ready),
    .txreq_opcode      (txreq_opcode),
    .txreq_excl        (txreq_excl),
    .txreq_lpid        (txreq_lpid),
    .txreq_addr        (txreq_addr),
    .txreq_txnid       (txreq_txnid),
    .rsp_valid         (rsp_valid),
    .rsp_lpid          (rsp_lpid),
    .rsp_resperr       (rsp_resperr),
    .snp_inv_valid     (snp_inv_valid),
    .snp_inv_addr      (snp_inv_addr),
    .excl_result_valid (excl_result_valid),
    .excl_result_lpid  (excl_result_lpid),
    .excl_result_pass  (excl_result_pass)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a request at the falling edge, confirm it is accepted, retire it on the next edge.
  task automatic req(input int lp, input logic st, input logic [ADDR_W-1:0] a, input string tag);
    core_req_valid = 1'b1;
    core_req_lpid  = LPID_W'(lp);
    core_req_store = st;
    core_req_addr  = a;
    #1 chk({tag, "_ready"}, 64'(core_req_ready), 64'd1);
    step();
    core_req_valid = 1'b0;
  endtask

  task automatic rsp(input int lp, input logic [1:0] err);
    rsp_valid   = 1'b1;
    rsp_lpid    = LPID_W'(lp);
    rsp_resperr = err;
    step();
    rsp_valid   = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic v, input int lp, input logic p);
    chk({tag, "_res_vld"}, 64'(excl_result_valid), 64'(v));
    if (v) begin
      chk({tag, "_res_lpid"}, 64'(excl_result_lpid), 64'(lp));
      chk({tag, "_res_pass"}, 64'(excl_result_pass), 64'(p));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; core_req_valid = 1'b0; core_req_lpid = '0; core_req_store = 1'b0;
    core_req_addr = '0; txreq_ready = 1'b1; rsp_valid = 1'b0; rsp_lpid = '0;
    rsp_resperr = 2'b00; snp_inv_valid = 1'b0; snp_inv_addr = '0;
    step(); step();
    chk("rst_txvld", 64'(txreq_valid), 64'd0);
    chk("rst_resvld", 64'(excl_result_valid), 64'd0);
    chk("rst_opcode", 64'(txreq_opcode), 64'd0);
    chk("rst_addr", 64'(txreq_addr), 64'd0);
    chk("rst_excl", 64'(txreq_excl), 64'd0);
    rst = 1'b0;
    step();

    // LP1: load, EXOKAY, store same line, EXOKAY -> pass, then LP1 back to IDLE
    req(1, 1'b0, 48'h1040, "t1_ld");
    chk("t1_ld_txvld", 64'(txreq_valid), 64'd1);
    chk("t1_ld_op", 64'(txreq_opcode), 64'h04);
    chk("t1_ld_excl", 64'(txreq_excl), 64'd1);
    chk("t1_ld_lpid", 64'(txreq_lpid), 64'd1);
    chk("t1_ld_addr", 64'(txreq_addr), 64'h1040);
    chk("t1_ld_txnid", 64'(txreq_txnid), 64'd1);
    step();
    chk("t1_drained", 64'(txreq_valid), 64'd0);
    rsp(1, 2'b01);
    chk_res("t1_ldrsp", 1'b1, 1, 1'b1);
    req(1, 1'b1, 48'h1078, "t1_st");
    chk_res("t1_st", 1'b0, 0, 1'b0);
    chk("t1_st_txvld", 64'(txreq_valid), 64'd1);
    chk("t1_st_op", 64'(txreq_opcode), 64'h1D);
    chk("t1_st_addr", 64'(txreq_addr), 64'h1078);
    chk("t1_st_txnid", 64'(txreq_txnid), 64'd1);
    rsp(1, 2'b01);
    chk_res("t1_strsp", 1'b1, 1, 1'b1);
    req(1, 1'b1, 48'h1078, "t1_st2");
    chk("t1_st2_txvld", 64'(txreq_valid), 64'd0);
    chk_res("t1_st2", 1'b1, 1, 1'b0);

    // LP2: store without a reservation fails locally, result is a single pulse
    req(2, 1'b1, 48'h0800, "t2_st");
    chk("t2_txvld", 64'(txreq_valid), 64'd0);
    chk_res("t2", 1'b1, 2, 1'b0);
    step();
    chk_res("t2_pulse", 1'b0, 0, 1'b0);

    // LP0: reservation killed by snoop to the same line (different byte)
    req(0, 1'b0, 48'h2000, "t3_ld");
    step();
    rsp(0, 2'b01);
    chk_res("t3_ldrsp", 1'b1, 0, 1'b1);
    snp_inv_valid = 1'b1; snp_inv_addr = 48'h2010;
    step();
    snp_inv_valid = 1'b0;
    req(0, 1'b1, 48'h2000, "t3_st");
    chk("t3_txvld", 64'(txreq_valid), 64'd0);
    chk_res("t3_st", 1'b1, 0, 1'b0);

    // LP0: snoop to another line leaves the reservation; store forwards, OK -> fail
    req(0, 1'b0, 48'h2000, "t3b_ld");
    step();
    rsp(0, 2'b01);
    snp_inv_valid = 1'b1; snp_inv_addr = 48'h2040;
    step();
    snp_inv_valid = 1'b0;
    req(0, 1'b1, 48'h203C, "t3b_st");
    chk("t3b_txvld", 64'(txreq_valid), 64'd1);
    chk("t3b_op", 64'(txreq_opcode), 64'h1D);
    rsp(0, 2'b00);
    chk_res("t3b_strsp", 1'b1, 0, 1'b0);

    // LP0: snoop and store in the same cycle -> snoop wins, store fails locally
    req(0, 1'b0, 48'h2000, "t3c_ld");
    step();
    rsp(0, 2'b01);
    snp_inv_valid = 1'b1; snp_inv_addr = 48'h2000;
    req(0, 1'b1, 48'h2000, "t3c_st");
    snp_inv_valid = 1'b0;
    chk("t3c_txvld", 64'(txreq_valid), 64'd0);
    chk_res("t3c_st", 1'b1, 0, 1'b0);

    // LP3: load answered OK -> fail, later store fails locally, stray response ignored
    req(3, 1'b0, 48'h3000, "t4_ld");
    step();
    rsp(3, 2'b00);
    chk_res("t4_ldrsp", 1'b1, 3, 1'b0);
    req(3, 1'b1, 48'h3000, "t4_st");
    chk("t4_txvld", 64'(txreq_valid), 64'd0);
    chk_res("t4_st", 1'b1, 3, 1'b0);
    rsp(3, 2'b01);
    chk_res("t4_stray", 1'b0, 0, 1'b0);

    // Link backpressure: flit held, new request stalls, accepted on the draining cycle
    txreq_ready = 1'b0;
    req(2, 1'b0, 48'h4000, "t5_ld");
    core_req_valid = 1'b1; core_req_lpid = 5'd1; core_req_store = 1'b0; core_req_addr = 48'h5000;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_stall_ready", 64'(core_req_ready), 64'd0);
      chk("t5_hold_vld", 64'(txreq_valid), 64'd1);
      chk("t5_hold_addr", 64'(txreq_addr), 64'h4000);
      chk("t5_hold_lpid", 64'(txreq_lpid), 64'd2);
      step();
    end
    txreq_ready = 1'b1;
    #1 chk("t5_drain_ready", 64'(core_req_ready), 64'd1);
    step();
    core_req_valid = 1'b0;
    chk("t5_b2b_vld", 64'(txreq_valid), 64'd1);
    chk("t5_b2b_lpid", 64'(txreq_lpid), 64'd1);
    chk("t5_b2b_addr", 64'(txreq_addr), 64'h5000);
    core_req_valid = 1'b1; core_req_lpid = 5'd1; core_req_store = 1'b0;
    #1 chk("t5_busy_lp_ready", 64'(core_req_ready), 64'd0);
    core_req_valid = 1'b0;
    rsp(2, 2'b00);
    chk_res("t5_rsp2", 1'b1, 2, 1'b0);
    rsp(1, 2'b00);
    chk_res("t5_rsp1", 1'b1, 1, 1'b0);

    // Response collides with a request: request stalls one cycle, results never overlap
    req(1, 1'b0, 48'h1000, "t6_ld");
    step();
    rsp_valid = 1'b1; rsp_lpid = 5'd1; rsp_resperr = 2'b01;
    core_req_valid = 1'b1; core_req_lpid = 5'd2; core_req_store = 1'b0; core_req_addr = 48'h6000;
    #1 chk("t6_coll_ready", 64'(core_req_ready), 64'd0);
    step();
    rsp_valid = 1'b0;
    chk_res("t6_rsp", 1'b1, 1, 1'b1);
    chk("t6_no_flit", 64'(txreq_valid), 64'd0);
    #1 chk("t6_retry_ready", 64'(core_req_ready), 64'd1);
    step();
    core_req_valid = 1'b0;
    chk("t6_flit_vld", 64'(txreq_valid), 64'd1);
    chk("t6_flit_lpid", 64'(txreq_lpid), 64'd2);
    chk("t6_flit_addr", 64'(txreq_addr), 64'h6000);
    chk_res("t6_no_overlap", 1'b0, 0, 1'b0);
    step();
    rsp(2, 2'b00);
    chk_res("t6_rsp2", 1'b1, 2, 1'b0);

    // Reset mid-transaction: pending flit and LP1 reservation dropped, late response ignored
    txreq_ready = 1'b0;
    req(0, 1'b0, 48'h7000, "t7_ld");
    chk("t7_pending", 64'(txreq_valid), 64'd1);
    rst = 1'b1;
    #1 chk("t7_rst_txvld", 64'(txreq_valid), 64'd0);
    step();
    rst = 1'b0;
    txreq_ready = 1'b1;
    rsp(0, 2'b01);
    chk_res("t7_late_rsp", 1'b0, 0, 1'b0);
    req(1, 1'b1, 48'h1000, "t7_st");
    chk("t7_st_txvld", 64'(txreq_valid), 64'd0);
    chk_res("t7_st", 1'b1, 1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
